// File: rtl/encoder_dram_pkg.sv
// Shared definitions for the encoder DRAM read path: request FSM states,
// AXI burst encoding and burst size arithmetic.
package encoder_dram_pkg;

    typedef enum logic [1:0] {
        RREQ_IDLE     = 2'd0,
        REQ_FIRST_MSG = 2'd1,
        REQ_MSG       = 2'd2,
        REQ_CIMG      = 2'd3
    } rreq_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    function automatic int unsigned burst_bytes(input int unsigned rburst_len,
                                                input int unsigned bytes_per_beat);
        return rburst_len * bytes_per_beat;
    endfunction

endpackage

// File: rtl/encoder_sat_updown_counter.sv
// Up/down counter that saturates at MAX_VAL and never decrements below zero;
// simultaneous inc and dec cancel.
module encoder_sat_updown_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 15
) (
    input  logic             axi_clk,
    input  logic             axi_resetn,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;

    // Next count with saturation at both ends
    always_comb begin
        count_s = count_r;
        if (inc && !dec) begin
            if (count_r != MAX_C) count_s = count_r + WIDTH'(1);
            else                  count_s = count_r;
        end else if (dec && !inc) begin
            if (count_r != '0) count_s = count_r - WIDTH'(1);
            else               count_s = count_r;
        end else begin
            count_s = count_r;
        end
    end

    // Count register
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) count_r <= '0;
        else             count_r <= count_s;
    end

    assign count = count_r;

endmodule

// File: rtl/encoder_dram_rreq_fsm.sv
// AXI4 AR request generator for the encoder: per frame two message bursts,
// then groups of cover-image bursts separated by single message bursts.
module encoder_dram_rreq_fsm
    import encoder_dram_pkg::*;
#(
    parameter int unsigned IMG_RBURST_LEN              = 128,
    parameter int unsigned NUM_RREQS_PER_CIMG          = 7200,
    parameter int unsigned NUM_CIMG_RREQS_PER_MSG_RREQ = 512,
    parameter int unsigned ADDR_WIDTH                  = 32,
    parameter int unsigned BYTES_PER_BEAT              = 16,
    parameter int unsigned MAX_OUTSTANDING             = 4
) (
    input  logic                  axi_clk,
    input  logic                  axi_resetn,
    input  logic                  begin_encoding,
    input  logic [ADDR_WIDTH-1:0] msg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cimg_base_addr,
    input  logic                  rburst_done,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    output logic                  busy,
    output logic                  finished_requesting_frame
);

    localparam int unsigned TOTAL_W  = $clog2(NUM_RREQS_PER_CIMG + 1);
    localparam int unsigned CONSEC_W = $clog2(NUM_CIMG_RREQS_PER_MSG_RREQ + 1);
    localparam int unsigned OUT_W    = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES =
        ADDR_WIDTH'(burst_bytes(IMG_RBURST_LEN, BYTES_PER_BEAT));
    localparam logic [TOTAL_W-1:0]  TOTAL_LAST  = TOTAL_W'(NUM_RREQS_PER_CIMG);
    localparam logic [CONSEC_W-1:0] CONSEC_LAST = CONSEC_W'(NUM_CIMG_RREQS_PER_MSG_RREQ);
    localparam logic [OUT_W-1:0]    OUT_MAX     = OUT_W'(MAX_OUTSTANDING);

    rreq_state_e           state_r, state_s;
    logic [ADDR_WIDTH-1:0] msg_addr_r, msg_addr_s;
    logic [ADDR_WIDTH-1:0] cimg_addr_r, cimg_addr_s;
    logic [TOTAL_W-1:0]    total_cnt_r, total_cnt_s;
    logic [CONSEC_W-1:0]   consec_cnt_r, consec_cnt_s;
    logic [ADDR_WIDTH-1:0] araddr_r, araddr_s;
    logic                  arvalid_r, arvalid_s;
    logic                  finished_r, finished_s;
    logic                  busy_r;
    logic                  frame_start_s;
    logic                  hs_s;
    logic [3:0]            pending_r;
    logic [OUT_W-1:0]      out_r, out_after_s;

    assign hs_s = arvalid_r && arready;

    encoder_sat_updown_counter #(.WIDTH(4), .MAX_VAL(15)) u_pending_cnt (
        .axi_clk    (axi_clk),
        .axi_resetn (axi_resetn),
        .inc        (begin_encoding),
        .dec        (frame_start_s),
        .count      (pending_r)
    );

    encoder_sat_updown_counter #(.WIDTH(OUT_W), .MAX_VAL(MAX_OUTSTANDING)) u_outstanding_cnt (
        .axi_clk    (axi_clk),
        .axi_resetn (axi_resetn),
        .inc        (hs_s),
        .dec        (rburst_done),
        .count      (out_r)
    );

    // Outstanding count as it will stand after this cycle's update
    always_comb begin
        out_after_s = out_r;
        if (hs_s && !rburst_done)                      out_after_s = out_r + OUT_W'(1);
        else if (!hs_s && rburst_done && out_r != '0)  out_after_s = out_r - OUT_W'(1);
        else                                           out_after_s = out_r;
    end

    // Request sequencing: state, address pointers and burst counters
    always_comb begin
        state_s       = state_r;
        msg_addr_s    = msg_addr_r;
        cimg_addr_s   = cimg_addr_r;
        total_cnt_s   = total_cnt_r;
        consec_cnt_s  = consec_cnt_r;
        finished_s    = 1'b0;
        frame_start_s = 1'b0;
        case (state_r)
            RREQ_IDLE: begin
                if (pending_r != 4'd0) begin
                    frame_start_s = 1'b1;
                    msg_addr_s    = msg_base_addr;
                    cimg_addr_s   = cimg_base_addr;
                    state_s       = REQ_FIRST_MSG;
                end else begin
                    state_s = RREQ_IDLE;
                end
            end
            REQ_FIRST_MSG: begin
                if (hs_s) begin
                    msg_addr_s = msg_addr_r + BURST_BYTES;
                    state_s    = REQ_MSG;
                end else begin
                    state_s = REQ_FIRST_MSG;
                end
            end
            REQ_MSG: begin
                if (hs_s) begin
                    msg_addr_s   = msg_addr_r + BURST_BYTES;
                    consec_cnt_s = CONSEC_W'(1);
                    state_s      = REQ_CIMG;
                end else begin
                    state_s = REQ_MSG;
                end
            end
            REQ_CIMG: begin
                if (hs_s) begin
                    cimg_addr_s = cimg_addr_r + BURST_BYTES;
                    if (total_cnt_r + TOTAL_W'(1) == TOTAL_LAST) begin
                        total_cnt_s  = '0;
                        consec_cnt_s = '0;
                        finished_s   = 1'b1;
                        state_s      = RREQ_IDLE;
                    end else if (consec_cnt_r == CONSEC_LAST) begin
                        total_cnt_s = total_cnt_r + TOTAL_W'(1);
                        state_s     = REQ_MSG;
                    end else begin
                        total_cnt_s  = total_cnt_r + TOTAL_W'(1);
                        consec_cnt_s = consec_cnt_r + CONSEC_W'(1);
                    end
                end else begin
                    state_s = REQ_CIMG;
                end
            end
            default: state_s = RREQ_IDLE;
        endcase
    end

    // AR channel: hold a presented request until accepted, else present the next one if credit allows
    always_comb begin
        arvalid_s = 1'b0;
        araddr_s  = araddr_r;
        if (arvalid_r && !arready) begin
            arvalid_s = 1'b1;
            araddr_s  = araddr_r;
        end else begin
            arvalid_s = (state_s != RREQ_IDLE) && (out_after_s < OUT_MAX);
            case (state_s)
                REQ_FIRST_MSG, REQ_MSG: araddr_s = msg_addr_s;
                REQ_CIMG:               araddr_s = cimg_addr_s;
                default:                araddr_s = araddr_r;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_r      <= RREQ_IDLE;
            msg_addr_r   <= '0;
            cimg_addr_r  <= '0;
            total_cnt_r  <= '0;
            consec_cnt_r <= '0;
            araddr_r     <= '0;
            arvalid_r    <= 1'b0;
            finished_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            msg_addr_r   <= msg_addr_s;
            cimg_addr_r  <= cimg_addr_s;
            total_cnt_r  <= total_cnt_s;
            consec_cnt_r <= consec_cnt_s;
            araddr_r     <= araddr_s;
            arvalid_r    <= arvalid_s;
            finished_r   <= finished_s;
            busy_r       <= (state_s != RREQ_IDLE);
        end
    end

    assign araddr                    = araddr_r;
    assign arvalid                   = arvalid_r;
    assign busy                      = busy_r;
    assign finished_requesting_frame = finished_r;
    assign arlen                     = 8'(IMG_RBURST_LEN - 1);
    assign arsize                    = 3'($clog2(BYTES_PER_BEAT));
    assign arburst                   = AXI_BURST_INCR;

endmodule

// File: tb/tb_encoder_dram_rreq_fsm.sv
// Directed and randomized bench for encoder_dram_rreq_fsm; expected AR order
// and addresses come from a per-frame request list built from the frame rules.
module tb_encoder_dram_rreq_fsm;

    localparam int unsigned LEN  = 4;
    localparam int unsigned NCI  = 5;
    localparam int unsigned KPM  = 2;
    localparam int unsigned BPB  = 16;
    localparam int unsigned MAXO = 4;
    localparam logic [31:0] BB   = 32'd64;

    logic        axi_clk = 1'b0;
    logic        axi_resetn, begin_encoding, rburst_done, arready;
    logic        arvalid, busy, finished_requesting_frame;
    logic [31:0] msg_base_addr, cimg_base_addr, araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    always #5 axi_clk = ~axi_clk;

    encoder_dram_rreq_fsm #(
        .IMG_RBURST_LEN(LEN), .NUM_RREQS_PER_CIMG(NCI), .NUM_CIMG_RREQS_PER_MSG_RREQ(KPM),
        .ADDR_WIDTH(32), .BYTES_PER_BEAT(BPB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .axi_clk(axi_clk), .axi_resetn(axi_resetn), .begin_encoding(begin_encoding),
        .msg_base_addr(msg_base_addr), .cimg_base_addr(cimg_base_addr),
        .rburst_done(rburst_done), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready), .busy(busy),
        .finished_requesting_frame(finished_requesting_frame)
    );

    typedef struct packed { logic [31:0] addr; logic last; } req_t;

    req_t exp_q[$];
    int   done_q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, model_out = 0, hs_cnt = 0, fin_cnt = 0;
    bit   auto_done = 1'b1, rand_ready = 1'b0;
    int   lat_min = 3, lat_max = 3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame request list: M, M, then KPM cover-image bursts per extra message burst
    task automatic push_frame(input logic [31:0] mb, input logic [31:0] cb);
        int m;
        exp_q.push_back('{addr: mb,      last: 1'b0});
        exp_q.push_back('{addr: mb + BB, last: 1'b0});
        m = 2;
        for (int c = 0; c < int'(NCI); c++) begin
            exp_q.push_back('{addr: cb + 32'(c) * BB, last: (c == int'(NCI) - 1)});
            if (((c + 1) % int'(KPM) == 0) && (c + 1 < int'(NCI))) begin
                exp_q.push_back('{addr: mb + 32'(m) * BB, last: 1'b0});
                m++;
            end
        end
    endtask

    task automatic tick();
        logic        pre_valid, pre_ready, pre_done, hs, exp_fin;
        logic [31:0] pre_addr;
        req_t        r;
        if (rand_ready) arready = 1'($urandom_range(0, 1));
        rburst_done = 1'b0;
        if (done_q.size() > 0 && done_q[0] <= cyc) begin
            rburst_done = 1'b1;
            void'(done_q.pop_front());
        end
        pre_valid = arvalid; pre_ready = arready; pre_addr = araddr; pre_done = rburst_done;
        @(posedge axi_clk);
        #1;
        cyc++;
        hs = pre_valid && pre_ready;
        exp_fin = 1'b0;
        if (hs) begin
            hs_cnt++;
            chk("ar_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                chk("ar_addr", 64'(pre_addr), 64'(r.addr));
                exp_fin = r.last;
            end
            model_out++;
            if (auto_done) done_q.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
        end
        if (pre_done) model_out--;
        chk("finished", 64'(finished_requesting_frame), 64'(exp_fin));
        if (exp_fin) begin
            fin_cnt++;
            chk("busy_at_finish", 64'(busy), 64'd0);
        end
        if (pre_valid && !pre_ready) begin
            chk("hold_valid", 64'(arvalid), 64'd1);
            chk("hold_addr", 64'(araddr), 64'(pre_addr));
        end
        if (arvalid) chk("credit", 64'(model_out < int'(MAXO)), 64'd1);
    endtask

    task automatic pulse_begin();
        begin_encoding = 1'b1;
        push_frame(msg_base_addr, cimg_base_addr);
        tick();
        begin_encoding = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() > 0 || model_out > 0 || done_q.size() > 0) && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n < max_cycles), 64'd1);
    endtask

    initial begin
        int hs0, fin0, n;
        axi_resetn = 1'b0; begin_encoding = 1'b0; rburst_done = 1'b0; arready = 1'b0;
        msg_base_addr = 32'h0; cimg_base_addr = 32'h0;

        // Reset state
        #12;
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_finished", 64'(finished_requesting_frame), 64'd0);
        chk("arlen", 64'(arlen), 64'd3);
        chk("arsize", 64'(arsize), 64'd4);
        chk("arburst", 64'(arburst), 64'd1);
        @(posedge axi_clk);
        #1;
        axi_resetn = 1'b1;
        tick(); tick();
        chk("idle_arvalid", 64'(arvalid), 64'd0);

        // Single frame, arready high, completions 3 cycles after each handshake
        msg_base_addr = 32'h1000; cimg_base_addr = 32'h8000; arready = 1'b1;
        hs0 = hs_cnt; fin0 = fin_cnt;
        pulse_begin();
        chk("lat_c1_valid", 64'(arvalid), 64'd0);
        tick();
        chk("lat_c2_valid", 64'(arvalid), 64'd1);
        chk("lat_c2_addr", 64'(araddr), 64'h1000);
        chk("lat_c2_busy", 64'(busy), 64'd1);
        drain(100);
        chk("frame1_ars", 64'(hs_cnt - hs0), 64'd9);
        chk("frame1_fins", 64'(fin_cnt - fin0), 64'd1);
        chk("frame1_busy", 64'(busy), 64'd0);

        // No completions: credit limit of 4, then one completion buys one more
        auto_done = 1'b0; hs0 = hs_cnt; fin0 = fin_cnt;
        pulse_begin();
        repeat (20) tick();
        chk("credit_ars", 64'(hs_cnt - hs0), 64'd4);
        chk("credit_stall", 64'(arvalid), 64'd0);
        done_q.push_back(cyc);
        repeat (10) tick();
        chk("credit_one_more", 64'(hs_cnt - hs0), 64'd5);
        chk("credit_stall2", 64'(arvalid), 64'd0);
        auto_done = 1'b1;
        for (int i = 0; i < model_out; i++) done_q.push_back(cyc + i);
        drain(100);
        chk("credit_fins", 64'(fin_cnt - fin0), 64'd1);

        // arready low for 5 cycles on the third request
        hs0 = hs_cnt; fin0 = fin_cnt;
        pulse_begin();
        n = 0;
        while (hs_cnt < hs0 + 2 && n < 50) begin tick(); n++; end
        chk("stall_reach", 64'(hs_cnt - hs0), 64'd2);
        arready = 1'b0;
        repeat (5) begin
            tick();
            chk("stall_valid", 64'(arvalid), 64'd1);
            chk("stall_addr", 64'(araddr), 64'h8000);
        end
        arready = 1'b1;
        drain(100);
        chk("stall_fins", 64'(fin_cnt - fin0), 64'd1);

        // Three back-to-back frame requests, random arready and completion latency
        hs0 = hs_cnt; fin0 = fin_cnt;
        lat_min = 1; lat_max = 6;
        begin_encoding = 1'b1;
        repeat (3) begin
            push_frame(msg_base_addr, cimg_base_addr);
            tick();
        end
        begin_encoding = 1'b0;
        rand_ready = 1'b1;
        drain(600);
        rand_ready = 1'b0; arready = 1'b1;
        chk("multi_ars", 64'(hs_cnt - hs0), 64'd27);
        chk("multi_fins", 64'(fin_cnt - fin0), 64'd3);
        repeat (5) tick();
        chk("multi_idle_valid", 64'(arvalid), 64'd0);
        chk("multi_idle_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of the cover-image phase
        lat_min = 3; lat_max = 3; hs0 = hs_cnt;
        pulse_begin();
        n = 0;
        while (hs_cnt < hs0 + 3 && n < 50) begin tick(); n++; end
        chk("rst_mid_reach", 64'(hs_cnt - hs0), 64'd3);
        #2;
        axi_resetn = 1'b0;
        #1;
        chk("rst_mid_arvalid", 64'(arvalid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        exp_q.delete(); done_q.delete(); model_out = 0;
        #2;
        axi_resetn = 1'b1;
        fin0 = fin_cnt;
        pulse_begin();
        tick();
        chk("restart_addr", 64'(araddr), 64'h1000);
        chk("restart_valid", 64'(arvalid), 64'd1);
        drain(100);
        chk("restart_fins", 64'(fin_cnt - fin0), 64'd1);

        // Message address wraps past the top of the address space
        msg_base_addr = 32'hFFFF_FFC0; cimg_base_addr = 32'h0002_0000;
        hs0 = hs_cnt;
        pulse_begin();
        n = 0;
        while (hs_cnt < hs0 + 1 && n < 50) begin tick(); n++; end
        chk("wrap_addr", 64'(araddr), 64'h0);
        drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
